exmem_elastic_reg: RTL and testbench

- Parametrised EX→MEM pipeline register for the pipelined core; successor to the fixed-width flop-only EX/MEM register.
- Adds a valid/ready elastic handshake with a one-entry skid buffer, so MEM back-pressure never drops an instruction.
- Adds a synchronous flush that converts in-flight entries into bubbles.
- Carries ALU result, store data, destination register and the four MEM/WB control bits.

---
 rtl/exmem_elastic_reg.sv | 122 ++++++++++++
 tb/tb_exmem_elastic_reg.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_elastic_reg.sv
// EX->MEM pipeline register with a valid/ready handshake and a one-entry skid
// buffer. M drives the outputs; S catches the entry accepted while M is stalled,
// so in_ready depends on registered state only. Flush turns held entries into
// bubbles, and reset also zeroes the stored fields.
module exmem_elastic_reg #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  // EX side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_alu_result,
  input  logic [WIDTH-1:0]  in_write_data,
  input  logic [ADDR_W-1:0] in_wa3,
  input  logic              in_pcsrc,
  input  logic              in_regwrite,
  input  logic              in_memwrite,
  input  logic              in_memtoreg,
  // MEM side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_alu_result,
  output logic [WIDTH-1:0]  out_write_data,
  output logic [ADDR_W-1:0] out_wa3,
  output logic              out_pcsrc,
  output logic              out_regwrite,
  output logic              out_memwrite,
  output logic              out_memtoreg,
  output logic [1:0]        occupancy
);

  // Packed entry layout: {alu_result, write_data, wa3, pcsrc, regwrite, memwrite, memtoreg}
  localparam int unsigned PW = 2 * WIDTH + ADDR_W + 4;

  logic [PW-1:0] in_pkt;
  logic [PW-1:0] m_q, m_d;
  logic [PW-1:0] s_q, s_d;
  logic          m_v_q, m_v_d;
  logic          s_v_q, s_v_d;
  logic          accept;
  logic          pop;

  assign in_pkt = {in_alu_result, in_write_data, in_wa3,
                   in_pcsrc, in_regwrite, in_memwrite, in_memtoreg};

  // S is only ever occupied while M is, so a free S means room for one more entry.
  assign in_ready  = ~s_v_q;
  assign out_valid = m_v_q;
  assign accept    = in_valid & in_ready;
  assign pop       = m_v_q & out_ready;

  // Next-state for both slots; flush drops all valid bits but leaves data untouched.
  always_comb begin
    m_d   = m_q;
    s_d   = s_q;
    m_v_d = m_v_q;
    s_v_d = s_v_q;
    if (flush) begin
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (pop && s_v_q) begin
      // Skid entry advances; a new entry refills S.
      m_d   = s_q;
      m_v_d = 1'b1;
      if (accept) begin
        s_d   = in_pkt;
        s_v_d = 1'b1;
      end else begin
        s_v_d = 1'b0;
      end
    end else if (pop) begin
      if (accept) begin
        m_d   = in_pkt;
        m_v_d = 1'b1;
      end else begin
        m_v_d = 1'b0;
      end
    end else if (m_v_q) begin
      // M stalled: park the new entry in S.
      if (accept) begin
        s_d   = in_pkt;
        s_v_d = 1'b1;
      end
    end else begin
      if (accept) begin
        m_d   = in_pkt;
        m_v_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset that also clears the payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q   <= '0;
      s_q   <= '0;
      m_v_q <= 1'b0;
      s_v_q <= 1'b0;
    end else begin
      m_q   <= m_d;
      s_q   <= s_d;
      m_v_q <= m_v_d;
      s_v_q <= s_v_d;
    end
  end

  // Output decode; control bits are gated so bubbles never write state downstream.
  always_comb begin
    out_alu_result = m_q[PW-1 -: WIDTH];
    out_write_data = m_q[PW-WIDTH-1 -: WIDTH];
    out_wa3        = m_q[4 +: ADDR_W];
    out_pcsrc      = m_q[3] & m_v_q;
    out_regwrite   = m_q[2] & m_v_q;
    out_memwrite   = m_q[1] & m_v_q;
    out_memtoreg   = m_q[0] & m_v_q;
    occupancy      = {1'b0, m_v_q} + {1'b0, s_v_q};
  end

endmodule

// File: tb/tb_exmem_elastic_reg.sv
// Self-checking bench for exmem_elastic_reg: directed scenarios plus a random
// run compared against a two-entry FIFO reference model.
module tb_exmem_elastic_reg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned PW     = 2 * WIDTH + ADDR_W + 4;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [WIDTH-1:0]  in_alu_result, in_write_data, out_alu_result, out_write_data;
  logic [ADDR_W-1:0] in_wa3, out_wa3;
  logic              in_pcsrc, in_regwrite, in_memwrite, in_memtoreg;
  logic              out_pcsrc, out_regwrite, out_memwrite, out_memtoreg;
  logic [1:0]        occupancy;

  int errors = 0;
  int checks = 0;

  // Reference model: ordered list of held entries plus the value last shown on the outputs.
  logic [PW-1:0] mq[$];
  logic [PW-1:0] m_shadow = '0;

  always #5 clk = ~clk;

  exmem_elastic_reg #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alu_result (in_alu_result),
    .in_write_data (in_write_data),
    .in_wa3        (in_wa3),
    .in_pcsrc      (in_pcsrc),
    .in_regwrite   (in_regwrite),
    .in_memwrite   (in_memwrite),
    .in_memtoreg   (in_memtoreg),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_alu_result(out_alu_result),
    .out_write_data(out_write_data),
    .out_wa3       (out_wa3),
    .out_pcsrc     (out_pcsrc),
    .out_regwrite  (out_regwrite),
    .out_memwrite  (out_memwrite),
    .out_memtoreg  (out_memtoreg),
    .occupancy     (occupancy)
  );

  task automatic drive(input logic v, input logic [WIDTH-1:0] alu, input logic [WIDTH-1:0] wd,
                       input logic [ADDR_W-1:0] wa, input logic [3:0] ctrl);
    in_valid      = v;
    in_alu_result = alu;
    in_write_data = wd;
    in_wa3        = wa;
    {in_pcsrc, in_regwrite, in_memwrite, in_memtoreg} = ctrl;
  endtask

  // Advance one clock and update the model from the inputs held across the edge.
  task automatic step();
    bit            do_pop, do_acc;
    logic [PW-1:0] pkt;
    logic [PW-1:0] dropped;
    pkt    = {in_alu_result, in_write_data, in_wa3,
              in_pcsrc, in_regwrite, in_memwrite, in_memtoreg};
    do_pop = (mq.size() > 0) && out_ready;
    do_acc = in_valid && (mq.size() < 2);
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_shadow = '0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (do_pop) dropped = mq.pop_front();
      if (do_acc) mq.push_back(pkt);
    end
    if (mq.size() > 0) m_shadow = mq[0];
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'h1234, 32'h5678, 4'h3, 4'hF);
    step();
    reset = 1'b0;
    drive(1'b0, '0, '0, '0, 4'h0);
    checks++;
    if ({out_valid, in_ready, occupancy} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_status: got valid/ready/occ=%b expected 0100",
               {out_valid, in_ready, occupancy});
    end
    checks++;
    if ({out_alu_result, out_write_data, out_wa3, out_pcsrc, out_regwrite, out_memwrite,
         out_memtoreg} !== '0) begin
      errors++;
      $display("FAIL reset_data: got alu=%h wd=%h wa3=%h expected all zero",
               out_alu_result, out_write_data, out_wa3);
    end
  endtask

  task automatic test_first_entry();
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h5, 4'b0110);
    step();
    drive(1'b0, '0, '0, '0, 4'h0);
    checks++;
    if ({out_valid, out_alu_result, out_write_data, out_wa3,
         out_pcsrc, out_regwrite, out_memwrite, out_memtoreg} !==
        {1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h5, 4'b0110}) begin
      errors++;
      $display("FAIL first_entry: got v=%b alu=%h wd=%h wa3=%h ctrl=%b expected 1 10 deadbeef 5 0110",
               out_valid, out_alu_result, out_write_data, out_wa3,
               {out_pcsrc, out_regwrite, out_memwrite, out_memtoreg});
    end
    step();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, WIDTH'(i), 32'h100 + WIDTH'(i), ADDR_W'(i), 4'b0100);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_alu_result !== WIDTH'(i) || occupancy > 2'd1 ||
          in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b alu=%0d occ=%0d rdy=%b expected v=1 alu=%0d occ<=1 rdy=1",
                 i, out_valid, out_alu_result, occupancy, in_ready, i);
      end
    end
    drive(1'b0, '0, '0, '0, 4'h0);
    step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL stream_drain: got v=%b occ=%0d expected v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_back_pressure();
    logic [WIDTH-1:0] seen[$];
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 32'h0, 4'h1, 4'b0100); step();
    drive(1'b1, 32'hB, 32'h0, 4'h2, 4'b0100); step();
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_alu_result !== 32'hA) begin
      errors++;
      $display("FAIL bp_full: got occ=%0d rdy=%b alu=%h expected occ=2 rdy=0 alu=a",
               occupancy, in_ready, out_alu_result);
    end
    drive(1'b1, 32'hC, 32'h0, 4'h3, 4'b0100); step();
    checks++;
    if (occupancy !== 2'd2 || out_alu_result !== 32'hA) begin
      errors++;
      $display("FAIL bp_hold: got occ=%0d alu=%h expected occ=2 alu=a", occupancy, out_alu_result);
    end
    // Keep C offered; collect every popped value in order.
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) seen.push_back(out_alu_result);
      if (in_valid && in_ready) begin
        step();
        drive(1'b0, '0, '0, '0, 4'h0);
      end else begin
        step();
      end
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 32'hA || seen[1] !== 32'hB || seen[2] !== 32'hC) begin
      errors++;
      $display("FAIL bp_order: got %0d entries first=%h expected a,b,c", seen.size(),
               (seen.size() > 0) ? seen[0] : 32'hX);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 32'h0, 4'h1, 4'b1111); step();
    drive(1'b1, 32'h22, 32'h0, 4'h2, 4'b1111); step();
    flush = 1'b1;
    drive(1'b1, 32'hDD, 32'h0, 4'h4, 4'b1111);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, 4'h0);
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 ||
        {out_pcsrc, out_regwrite, out_memwrite, out_memtoreg} !== 4'b0000 ||
        out_alu_result !== 32'h11) begin
      errors++;
      $display("FAIL flush: got v=%b occ=%0d rdy=%b ctrl=%b alu=%h expected 0 0 1 0000 11",
               out_valid, occupancy, in_ready,
               {out_pcsrc, out_regwrite, out_memwrite, out_memtoreg}, out_alu_result);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || out_alu_result === 32'hDD) begin
        errors++;
        $display("FAIL flush_ghost: got v=%b alu=%h expected v=0 and no dd", out_valid,
                 out_alu_result);
      end
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    drive(1'b1, 32'h77, 32'h88, 4'h9, 4'b1111);
    step();
    drive(1'b0, '0, '0, '0, 4'h0);
    checks++;
    if ({out_pcsrc, out_regwrite, out_memwrite, out_memtoreg} !== 4'b1111) begin
      errors++;
      $display("FAIL bubble_live: got ctrl=%b expected 1111",
               {out_pcsrc, out_regwrite, out_memwrite, out_memtoreg});
    end
    step();
    checks++;
    if ({out_valid, out_pcsrc, out_regwrite, out_memwrite, out_memtoreg} !== 5'b0 ||
        out_alu_result !== 32'h77) begin
      errors++;
      $display("FAIL bubble_gate: got v=%b ctrl=%b alu=%h expected v=0 ctrl=0000 alu=77", out_valid,
               {out_pcsrc, out_regwrite, out_memwrite, out_memtoreg}, out_alu_result);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 32'h31, 32'h41, 4'h6, 4'b1010); step();
    drive(1'b1, 32'h32, 32'h42, 4'h7, 4'b0101); step();
    reset = 1'b1; flush = 1'b1;
    drive(1'b1, 32'h33, 32'h43, 4'h8, 4'b1111);
    step();
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, '0, '0, '0, 4'h0);
    checks++;
    if ({out_valid, in_ready, occupancy} !== 4'b0100 ||
        {out_alu_result, out_write_data, out_wa3, out_pcsrc, out_regwrite, out_memwrite,
         out_memtoreg} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b rdy=%b occ=%0d alu=%h wd=%h expected 0 1 0 and zero data",
               out_valid, in_ready, occupancy, out_alu_result, out_write_data);
    end
  endtask

  task automatic test_random();
    logic [PW-1:0] exp_pkt;
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, ADDR_W'($urandom),
            4'($urandom));
      step();
      exp_pkt = m_shadow;
      if (mq.size() == 0) exp_pkt[3:0] = 4'b0000;
      checks++;
      if ({out_valid, in_ready, occupancy} !==
          {mq.size() > 0, mq.size() < 2, 2'(mq.size())}) begin
        errors++;
        $display("FAIL rand_status_%0d: got v=%b rdy=%b occ=%0d expected occ=%0d", c, out_valid,
                 in_ready, occupancy, mq.size());
      end
      checks++;
      if ({out_alu_result, out_write_data, out_wa3, out_pcsrc, out_regwrite, out_memwrite,
           out_memtoreg} !== exp_pkt) begin
        errors++;
        $display("FAIL rand_data_%0d: got alu=%h wd=%h wa3=%h ctrl=%b expected %h", c,
                 out_alu_result, out_write_data, out_wa3,
                 {out_pcsrc, out_regwrite, out_memwrite, out_memtoreg}, exp_pkt);
      end
    end
    reset = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0, '0, 4'h0);
    test_reset();
    test_first_entry();
    test_stream();
    test_back_pressure();
    test_flush();
    test_bubble();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
